// File: rtl/proc_run_pkg.sv
// Shared types and default run limits for the processor run controller.
// No logic; constants only.
// Imported by proc_run_ctrl and its bench.
package proc_run_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } run_state_e;

    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_MAX_CYCLES  = 50;
    localparam int DEF_STALL_LIMIT = 4;

endpackage

// File: rtl/pc_trace_ring.sv
// Ring of recently retired PCs with saturating fill count and newest-relative read.
// Latency: push lands on the next edge; read is combinational.
// No backpressure: a push always overwrites the oldest entry once full.
module pc_trace_ring #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic [PC_W-1:0]            push_pc,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [PC_W-1:0]            rd_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem [DEPTH];
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            count <= '0;
        end else if (push) begin
            wptr <= wptr + IDX_W'(1);
            if (count != (IDX_W+1)'(DEPTH))
                count <= count + (IDX_W+1)'(1);
        end
    end

    // Storage carries no reset; unfilled slots are masked by count on read.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wptr] <= push_pc;
    end

    // wptr points at the next free slot, so the newest entry sits one behind it.
    assign rd_ptr = wptr - IDX_W'(1) - rd_idx;
    assign rd_pc  = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: sequences core reset, bounds the run, detects same-PC halt, traces retires.
// Latency: termination is decided on post-update values and DONE is entered on that same edge.
// No backpressure: observes pc/pc_valid every cycle; start is only honoured from IDLE or DONE.
module proc_run_ctrl
    import proc_run_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [PC_W-1:0]                pc,
    input  logic                           pc_valid,
    output logic                           core_rst,
    output logic                           running,
    output logic                           done,
    output logic                           halted,
    output logic                           timeout,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [CNT_W-1:0]               retire_cnt,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]                trace_pc,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int ST_W = $clog2(STALL_LIMIT + 1);

    run_state_e       state, state_nxt;
    logic [RC_W-1:0]  rst_cnt;
    logic [ST_W-1:0]  stall, stall_nxt;
    logic [PC_W-1:0]  last_pc;
    logic             last_vld;
    logic [CNT_W-1:0] cyc_nxt, ret_nxt;
    logic             start_run, retire, hit_halt, hit_tmo;

    assign start_run = start && (state == S_IDLE || state == S_DONE);
    assign retire    = (state == S_RUN) && pc_valid;

    // Post-update values; counters stick at all-ones rather than wrap.
    always_comb begin
        cyc_nxt   = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);
        ret_nxt   = retire_cnt;
        stall_nxt = stall;
        if (retire) begin
            ret_nxt = (&retire_cnt) ? retire_cnt : retire_cnt + CNT_W'(1);
            if (last_vld && pc == last_pc)
                stall_nxt = (&stall) ? stall : stall + ST_W'(1);
            else
                stall_nxt = ST_W'(1);
        end
    end

    assign hit_halt = (state == S_RUN) && (stall_nxt >= ST_W'(STALL_LIMIT));
    assign hit_tmo  = (state == S_RUN) && (cyc_nxt >= CNT_W'(MAX_CYCLES));

    always_comb begin
        state_nxt = state;
        core_rst  = 1'b1;
        running   = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_RST;
            S_RST:  if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = S_RUN;
            S_RUN: begin
                core_rst = 1'b0;
                running  = 1'b1;
                if (hit_halt || hit_tmo) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_RST;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            stall      <= '0;
            last_pc    <= '0;
            last_vld   <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_run) begin
                rst_cnt    <= '0;
                cycle_cnt  <= '0;
                retire_cnt <= '0;
                stall      <= '0;
                last_vld   <= 1'b0;
                halted     <= 1'b0;
                timeout    <= 1'b0;
            end else if (state == S_RST) begin
                rst_cnt <= rst_cnt + RC_W'(1);
            end else if (state == S_RUN) begin
                cycle_cnt  <= cyc_nxt;
                retire_cnt <= ret_nxt;
                stall      <= stall_nxt;
                if (retire) begin
                    last_pc  <= pc;
                    last_vld <= 1'b1;
                end
                // A coincident budget expiry is reported as a halt.
                if (hit_halt)
                    halted <= 1'b1;
                else if (hit_tmo)
                    timeout <= 1'b1;
            end
        end
    end

    pc_trace_ring #(
        .PC_W  (PC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_run),
        .push    (retire),
        .push_pc (pc),
        .rd_idx  (trace_idx),
        .rd_pc   (trace_pc),
        .count   (trace_count)
    );

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: expectations queued at drive time, drained at observation.
// A second instance with a 6-cycle budget covers halt/timeout coincidence.
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start2 = 1'b0;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic [2:0]  trace_idx = '0;

    logic        core_rst, running, done, halted, timeout;
    logic [15:0] cycle_cnt, retire_cnt;
    logic [31:0] trace_pc;
    logic [3:0]  trace_count;

    logic        core_rst_b, running_b, done_b, halted_b, timeout_b;
    logic [15:0] cycle_cnt_b, retire_cnt_b;
    logic [31:0] trace_pc_b;
    logic [3:0]  trace_count_b;

    int n_checks = 0;
    int n_errors = 0;

    typedef enum int {K_CORE_RST, K_RUNNING, K_DONE, K_HALTED, K_TIMEOUT, K_CYC, K_RET,
                      K_TCNT, K_TRACE, K_HALTED_B, K_TIMEOUT_B, K_CYC_B, K_RUNNING_B} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ret_q[$];

    proc_run_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .pc_valid(pc_valid),
        .core_rst(core_rst), .running(running), .done(done), .halted(halted),
        .timeout(timeout), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
        .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_count(trace_count)
    );

    proc_run_ctrl #(.MAX_CYCLES(6)) u_dut_b (
        .clk(clk), .reset(reset), .start(start2), .pc(pc), .pc_valid(pc_valid),
        .core_rst(core_rst_b), .running(running_b), .done(done_b), .halted(halted_b),
        .timeout(timeout_b), .cycle_cnt(cycle_cnt_b), .retire_cnt(retire_cnt_b),
        .trace_idx(trace_idx), .trace_pc(trace_pc_b), .trace_count(trace_count_b)
    );

    always #50 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_CORE_RST:  return {31'd0, core_rst};
            K_RUNNING:   return {31'd0, running};
            K_DONE:      return {31'd0, done};
            K_HALTED:    return {31'd0, halted};
            K_TIMEOUT:   return {31'd0, timeout};
            K_CYC:       return {16'd0, cycle_cnt};
            K_RET:       return {16'd0, retire_cnt};
            K_TCNT:      return {28'd0, trace_count};
            K_TRACE:     return trace_pc;
            K_HALTED_B:  return {31'd0, halted_b};
            K_TIMEOUT_B: return {31'd0, timeout_b};
            K_CYC_B:     return {16'd0, cycle_cnt_b};
            K_RUNNING_B: return {31'd0, running_b};
            default:     return 32'hdead_beef;
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_e k, input int idx, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.idx = idx; e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == K_TRACE) begin
                trace_idx = 3'(e.idx);
                #1;
            end
            check(e.tag, observe(e.kind), e.exp);
        end
    endtask

    function automatic logic [31:0] model_trace(input int idx);
        int n = ret_q.size();
        int cnt = (n > 8) ? 8 : n;
        if (idx >= cnt) return 32'd0;
        return ret_q[n-1-idx];
    endfunction

    task automatic expect_trace(input string tag);
        int n = ret_q.size();
        expect_val($sformatf("%s_tcnt", tag), K_TCNT, 0, (n > 8) ? 32'd8 : 32'(n));
        for (int i = 0; i < 8; i++)
            expect_val($sformatf("%s_trace%0d", tag, i), K_TRACE, i, model_trace(i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] p, input logic v);
        pc = p;
        pc_valid = v;
        if (v) ret_q.push_back(p);
        step();
        pc_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        start2 = 1'b1;
        ret_q.delete();
        step();
        start = 1'b0;
        start2 = 1'b0;
        expect_val({tag, "_rst0_core_rst"}, K_CORE_RST, 0, 1);
        expect_val({tag, "_rst0_running"}, K_RUNNING, 0, 0);
        expect_val({tag, "_rst0_done"}, K_DONE, 0, 0);
        expect_val({tag, "_clr_cyc"}, K_CYC, 0, 0);
        expect_val({tag, "_clr_ret"}, K_RET, 0, 0);
        expect_val({tag, "_clr_halted"}, K_HALTED, 0, 0);
        expect_val({tag, "_clr_timeout"}, K_TIMEOUT, 0, 0);
        expect_val({tag, "_clr_tcnt"}, K_TCNT, 0, 0);
        drain();
        step();
        expect_val({tag, "_rst1_core_rst"}, K_CORE_RST, 0, 1);
        expect_val({tag, "_rst1_running"}, K_RUNNING, 0, 0);
        drain();
        step();
        expect_val({tag, "_run_core_rst"}, K_CORE_RST, 0, 0);
        expect_val({tag, "_run_running"}, K_RUNNING, 0, 1);
        drain();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            step();
            n++;
        end
        check({tag, "_done_reached"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2 reset = 1'b0;
        #2;
        expect_val("reset_core_rst", K_CORE_RST, 0, 1);
        expect_val("reset_running", K_RUNNING, 0, 0);
        expect_val("reset_done", K_DONE, 0, 0);
        expect_val("reset_halted", K_HALTED, 0, 0);
        expect_val("reset_timeout", K_TIMEOUT, 0, 0);
        expect_val("reset_cyc", K_CYC, 0, 0);
        expect_val("reset_ret", K_RET, 0, 0);
        expect_val("reset_tcnt", K_TCNT, 0, 0);
        drain();
        step();
        step();
        reset = 1'b1;
        step();

        // Budget expiry with a steadily advancing PC.
        do_start("t1");
        for (int i = 0; i < 50; i++) begin
            if (i == 49) begin
                expect_val("t1_pre_running", K_RUNNING, 0, 1);
                expect_val("t1_pre_timeout", K_TIMEOUT, 0, 0);
                expect_val("t1_pre_cyc", K_CYC, 0, 49);
                drain();
            end
            retire(32'(i * 4), 1'b1);
        end
        expect_val("t1_done", K_DONE, 0, 1);
        expect_val("t1_timeout", K_TIMEOUT, 0, 1);
        expect_val("t1_halted", K_HALTED, 0, 0);
        expect_val("t1_core_rst", K_CORE_RST, 0, 1);
        expect_val("t1_cyc", K_CYC, 0, 50);
        expect_val("t1_ret", K_RET, 0, 50);
        expect_trace("t1");
        drain();
        pc = 32'h999;
        pc_valid = 1'b1;
        step();
        step();
        pc_valid = 1'b0;
        expect_val("t1_frozen_ret", K_RET, 0, 50);
        expect_val("t1_frozen_cyc", K_CYC, 0, 50);
        expect_val("t1_frozen_done", K_DONE, 0, 1);
        expect_trace("t1_frozen");
        drain();

        // Self-loop halt.
        do_start("t2");
        retire(32'h0, 1'b1);
        retire(32'h4, 1'b1);
        retire(32'h8, 1'b1);
        retire(32'h8, 1'b1);
        retire(32'h8, 1'b1);
        expect_val("t2_pre_halted", K_HALTED, 0, 0);
        expect_val("t2_pre_running", K_RUNNING, 0, 1);
        drain();
        retire(32'h8, 1'b1);
        expect_val("t2_halted", K_HALTED, 0, 1);
        expect_val("t2_timeout", K_TIMEOUT, 0, 0);
        expect_val("t2_done", K_DONE, 0, 1);
        expect_val("t2_ret", K_RET, 0, 6);
        expect_val("t2_cyc", K_CYC, 0, 6);
        expect_val("t2_idx3", K_TRACE, 3, 32'h8);
        expect_val("t2_idx4", K_TRACE, 4, 32'h4);
        expect_val("t2_idx6_empty", K_TRACE, 6, 32'h0);
        expect_trace("t2");
        drain();

        // Ring wrap, then start ignored while running.
        do_start("t3");
        for (int i = 0; i < 12; i++)
            retire(32'(i * 4), 1'b1);
        expect_val("t3_tcnt_sat", K_TCNT, 0, 8);
        expect_val("t3_idx0", K_TRACE, 0, 32'h2C);
        expect_val("t3_idx7", K_TRACE, 7, 32'h10);
        expect_val("t3_cyc12", K_CYC, 0, 12);
        expect_trace("t3");
        drain();
        start = 1'b1;
        step();
        start = 1'b0;
        expect_val("t3_ign_running", K_RUNNING, 0, 1);
        expect_val("t3_ign_cyc", K_CYC, 0, 13);
        expect_val("t3_ign_tcnt", K_TCNT, 0, 8);
        drain();
        wait_done("t3");
        expect_val("t3_timeout", K_TIMEOUT, 0, 1);
        expect_val("t3_halted", K_HALTED, 0, 0);
        expect_val("t3_cyc", K_CYC, 0, 50);
        expect_val("t3_ret", K_RET, 0, 12);
        drain();

        // Same-PC stall across pc_valid gaps; instance b also hits its budget here.
        do_start("t4");
        retire(32'h10, 1'b1);
        retire(32'h0, 1'b0);
        retire(32'h10, 1'b1);
        retire(32'h0, 1'b0);
        retire(32'h10, 1'b1);
        expect_val("t4_pre_halted", K_HALTED, 0, 0);
        expect_val("t4_pre_running_b", K_RUNNING_B, 0, 1);
        drain();
        retire(32'h10, 1'b1);
        expect_val("t4_halted", K_HALTED, 0, 1);
        expect_val("t4_timeout", K_TIMEOUT, 0, 0);
        expect_val("t4_ret", K_RET, 0, 4);
        expect_val("t4_halted_b", K_HALTED_B, 0, 1);
        expect_val("t4_timeout_b", K_TIMEOUT_B, 0, 0);
        expect_val("t4_cyc_b", K_CYC_B, 0, 6);
        expect_trace("t4");
        drain();

        // Async reset in the middle of a run.
        do_start("t5");
        for (int i = 0; i < 20; i++)
            retire(32'h100 + 32'(i * 4), 1'b1);
        expect_val("t5_cyc20", K_CYC, 0, 20);
        drain();
        reset = 1'b0;
        #1;
        expect_val("t5_core_rst", K_CORE_RST, 0, 1);
        expect_val("t5_running", K_RUNNING, 0, 0);
        expect_val("t5_cyc", K_CYC, 0, 0);
        expect_val("t5_ret", K_RET, 0, 0);
        expect_val("t5_tcnt", K_TCNT, 0, 0);
        expect_val("t5_idx0_empty", K_TRACE, 0, 32'h0);
        drain();
        step();
        step();
        reset = 1'b1;
        step();
        expect_val("t5_idle_core_rst", K_CORE_RST, 0, 1);
        expect_val("t5_idle_running", K_RUNNING, 0, 0);
        drain();
        do_start("t6");
        retire(32'h40, 1'b1);
        retire(32'h44, 1'b1);
        retire(32'h48, 1'b1);
        expect_val("t6_ret", K_RET, 0, 3);
        expect_trace("t6");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
